rf_wb_queue: RTL and testbench
==============================

# rf_wb_queue

Write-back queue that drives the write port of the 8×16-bit register file. It accepts (address, data) results from the execute/load stage over a valid/ready handshake and buffers them in an in-order FIFO. It retires at most one entry per cycle into the register file when `drain_en` is high. It also reports whether a register being read still has a pending write, and can optionally forward that pending data.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `ADDR_W`, 3, register address width (2**ADDR_W registers)
- `DEPTH`, 4, queue entries; power of two, ≥2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  producer has a write result
- `in_ready`  out  1  queue can accept; equals `!full`
- `in_addr`  in  ADDR_W  destination register
- `in_data`  in  DATA_W  result value
- `drain_en`  in  1  register-file write slot available this cycle
- `wr_en`  out  1  to register file `en`
- `wr_addr`  out  ADDR_W  to register file `wr_addr`
- `wr_data`  out  DATA_W  to register file `wr_data`
- `rs_addr`, `rt_addr`  in  ADDR_W  read addresses, same values presented to the register file
- `rs_pend`, `rt_pend`  out  1  a queued entry targets that address
- `rs_fwd`, `rt_fwd`  out  DATA_W  youngest matching queued data (present only with RF_WB_FWD_EN)
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `full`, `empty`  out  1  status

## Operation
- Storage: DEPTH entries of {addr, data, valid}. Head pointer `rd_ptr`, tail pointer `wr_ptr`, each $clog2(DEPTH) bits and wrapping modulo DEPTH. `count` tracks occupancy.
- Push: `in_valid && in_ready` writes {in_addr, in_data} at `wr_ptr`, then increments `wr_ptr`.
- Pop: `wr_en = drain_en && !empty`. `wr_addr` and `wr_data` are driven combinationally from the head entry. When `wr_en` is high, the head entry is invalidated and `rd_ptr` increments.
- Push and pop in the same cycle: both occur and `count` is unchanged.
- Full: `in_ready = 0` and no push is accepted, even if a pop occurs in the same cycle (no fall-through).
- Empty: `wr_en = 0`, and `wr_addr`/`wr_data` are 0. No bypass from `in_*` to `wr_*`.
- Order: entries retire strictly in arrival order. Duplicate addresses are all written, and the last one wins in the register file.
- Hazard lookup: `rs_pend` is high if any valid stored entry has addr == `rs_addr`. The entry being retired this cycle still counts, because the register file updates at this clock edge. An entry being pushed this cycle does not count. `rt_pend` is identical for `rt_addr`.
- Address 0 is an ordinary register and receives no special treatment.

## Timing
- Reset (sync): pointers, count and all valid bits are cleared. `in_ready` = 1, `empty` = 1, `full` = 0, `count` = 0. `wr_en` = 0 and `wr_addr`/`wr_data` = 0. `*_pend` = 0 and `*_fwd` = 0.
- `rst` takes priority over push and drain in the same cycle. An `in_valid` during reset is dropped.
- Minimum latency: push at edge N, earliest `wr_en` in cycle N+1, and the register file holds the value after edge N+1.
- Throughput: one push and one retire per cycle sustained.
- All outputs except `wr_*`, `*_pend` and `*_fwd` are registered state. Those three groups are combinational from state plus `drain_en`/read addresses, with no input-to-output path from `in_*`.

## Configuration
- `RF_WB_FWD_EN` defined: `rs_fwd`/`rt_fwd` exist. Each carries the data of the youngest valid matching entry, with priority given to the entry closest to `wr_ptr`. Each is 0 when there is no match.
- Undefined: the forward ports and their priority logic are absent. Only `*_pend` is provided, and the pipeline stalls on pend.

## Structure
- Package `rf_pkg`:
  - `RF_DATA_W` = 16 and `RF_ADDR_W` = 3
  - typedef `rf_wb_entry_t` {valid, addr, data}
- Sub-module `rf_wb_match`: youngest-first address search over the entry array. Inputs are the entries, `rd_ptr` and a lookup address. Outputs are `hit` and `data`. It is instantiated twice, once for rs and once for rt.

## Test plan
- Reset, then push {3, 0x1234} with `drain_en` = 1: `wr_en` = 1, `wr_addr` = 3, `wr_data` = 0x1234 in the next cycle, then `empty` = 1.
- `drain_en` = 0, push 4 entries: `full` = 1 and `in_ready` = 0. A fifth push is refused and `count` stays at 4. Raise `drain_en`: the entries retire in order over 4 cycles.
- Push {5, 0xAAAA}, then {5, 0xBBBB}, with `rs_addr` = 5: `rs_pend` = 1 and (FWD) `rs_fwd` = 0xBBBB. After both retire, `rs_pend` = 0.
- Run simultaneous push and pop for 10 cycles starting from `count` = 2: `count` stays at 2, the pointers wrap, and the data order is preserved.
- Assert `rst` while 3 entries are queued: in the next cycle `count` = 0 and `wr_en` = 0, and no stale write occurs afterwards.
- `rt_addr` = 2 while {2, x} is being pushed this cycle: `rt_pend` = 0. It becomes 1 in the next cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared widths and the write-back queue entry type for the 8x16 register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_entry_t;

endpackage

// File: rtl/rf_wb_match.sv
// Address search over the write-back queue entries; with RF_WB_FWD_EN defined it also returns
// the data of the youngest matching entry.
module rf_wb_match
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     ent_valid,
  input  logic [RF_ADDR_W-1:0] ent_addr [DEPTH],
`ifdef RF_WB_FWD_EN
  input  logic [RF_DATA_W-1:0] ent_data [DEPTH],
  input  logic [PTR_W-1:0]     rd_ptr,
  output logic [RF_DATA_W-1:0] data,
`endif
  input  logic [RF_ADDR_W-1:0] addr,
  output logic                 hit
);

`ifdef RF_WB_FWD_EN
  // Walk oldest to youngest from the head so the last match seen is the youngest one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == addr)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
`else
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == addr)) begin
        hit = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wb_queue.sv
// In-order write-back queue feeding the register file write port, with read-hazard lookup.
// Optional feature macro: RF_WB_FWD_EN adds rs_fwd/rt_fwd youngest-entry forwarding.
module rf_wb_queue
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     drain_en,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rs_addr,
  input  logic [ADDR_W-1:0]        rt_addr,
  output logic                     rs_pend,
  output logic                     rt_pend,
`ifdef RF_WB_FWD_EN
  output logic [DATA_W-1:0]        rs_fwd,
  output logic [DATA_W-1:0]        rt_fwd,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  rf_wb_entry_t      entries_q [DEPTH];
  rf_wb_entry_t      entries_d [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;

  logic              push, pop;
  rf_wb_entry_t      head;

  // Full blocks a push even when a pop happens the same cycle: no fall-through.
  assign push = in_valid && !full_q;
  assign pop  = drain_en && !empty_q;
  assign head = entries_q[rd_ptr_q];

  always_comb begin
    entries_d = entries_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (pop) begin
      entries_d[rd_ptr_q].valid = 1'b0;
      rd_ptr_d                  = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      entries_d[wr_ptr_q] = '{valid: 1'b1, addr: in_addr, data: in_data};
      wr_ptr_d            = wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      entries_q <= entries_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign wr_en    = pop;
  assign wr_addr  = empty_q ? '0 : head.addr;
  assign wr_data  = empty_q ? '0 : head.data;

  // Lookup only sees stored entries, so a push in flight this cycle never raises pend.
  logic [DEPTH-1:0]     ent_valid;
  logic [RF_ADDR_W-1:0] ent_addr [DEPTH];
`ifdef RF_WB_FWD_EN
  logic [RF_DATA_W-1:0] ent_data [DEPTH];
`endif

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = entries_q[i].valid;
      ent_addr[i]  = entries_q[i].addr;
`ifdef RF_WB_FWD_EN
      ent_data[i]  = entries_q[i].data;
`endif
    end
  end

  rf_wb_match #(
    .DEPTH (DEPTH)
  ) u_match_rs (
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
`ifdef RF_WB_FWD_EN
    .ent_data  (ent_data),
    .rd_ptr    (rd_ptr_q),
    .data      (rs_fwd),
`endif
    .addr      (rs_addr),
    .hit       (rs_pend)
  );

  rf_wb_match #(
    .DEPTH (DEPTH)
  ) u_match_rt (
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr),
`ifdef RF_WB_FWD_EN
    .ent_data  (ent_data),
    .rd_ptr    (rd_ptr_q),
    .data      (rt_fwd),
`endif
    .addr      (rt_addr),
    .hit       (rt_pend)
  );

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed vector table, corner sequences, random vs model.
module tb_rf_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        drain_en;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rs_addr, rt_addr;
  logic        rs_pend, rt_pend;
`ifdef RF_WB_FWD_EN
  logic [15:0] rs_fwd, rt_fwd;
`endif
  logic [2:0]  count;
  logic        full, empty;

  always #5 clk = ~clk;

  rf_wb_queue #(
    .DATA_W (16),
    .ADDR_W (3),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_pend  (rs_pend),
    .rt_pend  (rt_pend),
`ifdef RF_WB_FWD_EN
    .rs_fwd   (rs_fwd),
    .rt_fwd   (rt_fwd),
`endif
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the queue contents in arrival order.
  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
  } ent_t;
  ent_t mq[$];

  task automatic chk(string tag, string what, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %0h want %0h", tag, what, got, want);
    end
  endtask

  function automatic logic m_pend(logic [2:0] a);
    foreach (mq[i]) if (mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_fwd(logic [2:0] a);
    logic [15:0] r = '0;
    foreach (mq[i]) if (mq[i].a == a) r = mq[i].d;
    return r;
  endfunction

  task automatic cmp_model(string tag);
    int n = mq.size();
    chk(tag, "count", 32'(count), 32'(n));
    chk(tag, "full", 32'(full), 32'(n == 4));
    chk(tag, "empty", 32'(empty), 32'(n == 0));
    chk(tag, "in_ready", 32'(in_ready), 32'(n != 4));
    chk(tag, "wr_en", 32'(wr_en), 32'(drain_en && n > 0));
    chk(tag, "wr_addr", 32'(wr_addr), (n > 0) ? 32'(mq[0].a) : 32'd0);
    chk(tag, "wr_data", 32'(wr_data), (n > 0) ? 32'(mq[0].d) : 32'd0);
    chk(tag, "rs_pend", 32'(rs_pend), 32'(m_pend(rs_addr)));
    chk(tag, "rt_pend", 32'(rt_pend), 32'(m_pend(rt_addr)));
`ifdef RF_WB_FWD_EN
    chk(tag, "rs_fwd", 32'(rs_fwd), 32'(m_fwd(rs_addr)));
    chk(tag, "rt_fwd", 32'(rt_fwd), 32'(m_fwd(rt_addr)));
`endif
  endtask

  // Called 1 time unit after a rising edge with inputs already applied.
  task automatic tick(string tag, bit do_cmp);
    bit pop, push;
    #3;
    if (do_cmp) cmp_model(tag);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      pop  = drain_en && (mq.size() > 0);
      push = in_valid && (mq.size() < 4);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{a: in_addr, d: in_data});
    end
    #1;
  endtask

  typedef struct packed {
    logic        iv;
    logic [2:0]  ia;
    logic [15:0] id;
    logic        dr;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        e_wr_en;
    logic [2:0]  e_wa;
    logic [15:0] e_wd;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_rsp;
    logic        e_rtp;
    logic [15:0] e_rsf;
  } vec_t;

  vec_t vecs [20];

  initial begin
    // iv ia id dr rs rt | wr_en wa wd cnt full rsp rtp rs_fwd  (pre-edge values)
    vecs[0]  = '{1, 3, 'h1234, 1, 3, 0,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[1]  = '{0, 0, 'h0000, 1, 3, 3,  1, 3, 'h1234, 1, 0, 1, 1, 'h1234};
    vecs[2]  = '{0, 0, 'h0000, 0, 3, 0,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[3]  = '{1, 1, 'h1111, 0, 1, 2,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[4]  = '{1, 2, 'h2222, 0, 1, 2,  0, 1, 'h1111, 1, 0, 1, 0, 'h1111};
    vecs[5]  = '{1, 0, 'h3333, 0, 1, 2,  0, 1, 'h1111, 2, 0, 1, 1, 'h1111};
    vecs[6]  = '{1, 7, 'h4444, 0, 0, 7,  0, 1, 'h1111, 3, 0, 1, 0, 'h3333};
    vecs[7]  = '{1, 6, 'h5555, 0, 7, 6,  0, 1, 'h1111, 4, 1, 1, 0, 'h4444};
    vecs[8]  = '{1, 6, 'h5555, 1, 6, 1,  1, 1, 'h1111, 4, 1, 0, 1, 'h0000};
    vecs[9]  = '{0, 0, 'h0000, 1, 6, 2,  1, 2, 'h2222, 3, 0, 0, 1, 'h0000};
    vecs[10] = '{0, 0, 'h0000, 1, 0, 2,  1, 0, 'h3333, 2, 0, 1, 0, 'h3333};
    vecs[11] = '{0, 0, 'h0000, 1, 7, 6,  1, 7, 'h4444, 1, 0, 1, 0, 'h4444};
    vecs[12] = '{0, 0, 'h0000, 1, 7, 6,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[13] = '{1, 5, 'hAAAA, 0, 5, 2,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[14] = '{1, 5, 'hBBBB, 0, 5, 2,  0, 5, 'hAAAA, 1, 0, 1, 0, 'hAAAA};
    vecs[15] = '{0, 0, 'h0000, 1, 5, 2,  1, 5, 'hAAAA, 2, 0, 1, 0, 'hBBBB};
    vecs[16] = '{0, 0, 'h0000, 1, 5, 2,  1, 5, 'hBBBB, 1, 0, 1, 0, 'hBBBB};
    vecs[17] = '{0, 0, 'h0000, 0, 5, 2,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[18] = '{1, 2, 'h0C0C, 0, 5, 2,  0, 0, 'h0000, 0, 0, 0, 0, 'h0000};
    vecs[19] = '{0, 0, 'h0000, 0, 5, 2,  0, 2, 'h0C0C, 1, 0, 0, 1, 'h0000};

    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    drain_en = 1'b0; rs_addr = '0; rt_addr = '0;
    @(posedge clk); #1;
    tick("reset", 1'b0);
    tick("reset", 1'b0);

    // Reset state, with drain requested on an empty queue.
    rst = 1'b0; drain_en = 1'b1;
    #3;
    chk("reset", "in_ready", 32'(in_ready), 32'd1);
    chk("reset", "empty", 32'(empty), 32'd1);
    chk("reset", "full", 32'(full), 32'd0);
    chk("reset", "count", 32'(count), 32'd0);
    chk("reset", "wr_en", 32'(wr_en), 32'd0);
    chk("reset", "wr_addr", 32'(wr_addr), 32'd0);
    chk("reset", "wr_data", 32'(wr_data), 32'd0);
    chk("reset", "rs_pend", 32'(rs_pend), 32'd0);
    chk("reset", "rt_pend", 32'(rt_pend), 32'd0);
`ifdef RF_WB_FWD_EN
    chk("reset", "rs_fwd", 32'(rs_fwd), 32'd0);
`endif
    tick("reset_idle", 1'b1);

    for (int i = 0; i < 20; i++) begin
      string tag;
      vec_t v;
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      in_valid = v.iv; in_addr = v.ia; in_data = v.id;
      drain_en = v.dr; rs_addr = v.rs; rt_addr = v.rt;
      #3;
      chk(tag, "wr_en", 32'(wr_en), 32'(v.e_wr_en));
      chk(tag, "wr_addr", 32'(wr_addr), 32'(v.e_wa));
      chk(tag, "wr_data", 32'(wr_data), 32'(v.e_wd));
      chk(tag, "count", 32'(count), 32'(v.e_cnt));
      chk(tag, "full", 32'(full), 32'(v.e_full));
      chk(tag, "in_ready", 32'(in_ready), 32'(!v.e_full));
      chk(tag, "rs_pend", 32'(rs_pend), 32'(v.e_rsp));
      chk(tag, "rt_pend", 32'(rt_pend), 32'(v.e_rtp));
`ifdef RF_WB_FWD_EN
      chk(tag, "rs_fwd", 32'(rs_fwd), 32'(v.e_rsf));
`endif
      tick(tag, 1'b1);
    end

    // Reset with three entries queued (one left by the table), push and drain also asserted.
    drain_en = 1'b0; in_valid = 1'b1; rs_addr = 3'd4;
    in_addr = 3'd4; in_data = 16'h4040; tick("rstq_fill", 1'b1);
    in_addr = 3'd6; in_data = 16'h6060; tick("rstq_fill", 1'b1);
    in_valid = 1'b0;
    #3;
    chk("rstq_pre", "count", 32'(count), 32'd3);
    chk("rstq_pre", "rs_pend", 32'(rs_pend), 32'd1);
    tick("rstq_pre", 1'b1);
    rst = 1'b1; in_valid = 1'b1; in_addr = 3'd1; in_data = 16'h7777; drain_en = 1'b1;
    tick("rstq_rst", 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("rstq_post", "count", 32'(count), 32'd0);
      chk("rstq_post", "wr_en", 32'(wr_en), 32'd0);
      chk("rstq_post", "rs_pend", 32'(rs_pend), 32'd0);
      tick("rstq_post", 1'b1);
    end

    // Sustained push+pop from count 2: occupancy constant, pointers wrap, order kept.
    drain_en = 1'b0; in_valid = 1'b1;
    in_addr = 3'd1; in_data = 16'h0100; tick("pp_fill", 1'b1);
    in_addr = 3'd2; in_data = 16'h0101; tick("pp_fill", 1'b1);
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] exp_d;
      exp_d = (i < 2) ? 16'(16'h0100 + i) : 16'(16'h0200 + i - 2);
      in_addr = 3'(i); in_data = 16'(16'h0200 + i);
      #3;
      chk("pushpop", "count", 32'(count), 32'd2);
      chk("pushpop", "wr_en", 32'(wr_en), 32'd1);
      chk("pushpop", "wr_data", 32'(wr_data), 32'(exp_d));
      tick("pushpop", 1'b1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick("pp_drain", 1'b1);

    // Random traffic against the model; drain pressure shifts halfway through.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 79) == 0);
      in_valid = ($urandom_range(0, 99) < 60);
      in_addr  = 3'($urandom_range(0, 7));
      in_data  = 16'($urandom);
      drain_en = ($urandom_range(0, 99) < ((i < 300) ? 35 : 75));
      rs_addr  = 3'($urandom_range(0, 7));
      rt_addr  = 3'($urandom_range(0, 7));
      tick("random", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
